// File: rtl/mem_access_pkg.sv
// Purpose: access codes, FSM state and request descriptor shared by the decoder and the memory stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_pkg;

    // MEM_READ / MEM_WRITE access codes; store codes reuse MEM_B/MEM_H/MEM_W.
    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_B    = 3'b001;
    localparam logic [2:0] MEM_H    = 3'b010;
    localparam logic [2:0] MEM_W    = 3'b011;
    localparam logic [2:0] MEM_BU   = 3'b100;
    localparam logic [2:0] MEM_HU   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Decoded request, latched for the duration of the access.
    typedef struct packed {
        logic      is_store;
        acc_size_t size;
        logic      is_unsigned;
    } acc_req_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input acc_size_t size, input logic [1:0] offset);
        logic r;
        r = 1'b0;
        case (size)
            SZ_HALF: r = offset[0];
            SZ_WORD: r = (offset != 2'b00);
            default: r = 1'b0;
        endcase
        is_misaligned = r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Purpose: pick the addressed byte/halfword out of a memory word and sign- or zero-extend it.
// Latency: combinational.
// Backpressure: none.
// Ports: i_word memory word, i_size access size, i_unsigned zero-extend select,
//        i_offset byte offset ADDRESS[1:0], o_result extended 32-bit load value.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  acc_size_t   i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Halfword lane is chosen by offset[1] only; offset[0] is guaranteed 0 for halves.
    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_size)
            SZ_BYTE: o_result = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Purpose: memory-stage responder executing decoded loads/stores against a ready-handshaked word memory.
// Latency: BUSY in IDLE and ACCESS, DONE one cycle after M_READY (min 2 busy cycles); misaligned goes straight to DONE.
// Backpressure: holds strobes until M_READY or TIMEOUT_CYCLES elapse; stalls the pipeline through BUSY.
// Ports: CLK/RESET clock and async active-high reset; MEM_READ/MEM_WRITE access codes; ADDRESS byte address;
//        WRITE_DATA store source; READ_DATA extended load result; BUSY stall; MISALIGNED/TIMEOUT one-cycle
//        fault pulses in DONE; M_READ/M_WRITE/M_ADDR/M_WDATA/M_BYTE_EN memory request; M_RDATA/M_READY response.
module dmem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [2:0]            MEM_READ,
    input  logic [2:0]            MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSY,
    output logic                  MISALIGNED,
    output logic                  TIMEOUT,
    output logic                  M_READ,
    output logic                  M_WRITE,
    output logic [ADDR_WIDTH-3:0] M_ADDR,
    output logic [31:0]           M_WDATA,
    output logic [3:0]            M_BYTE_EN,
    input  logic [31:0]           M_RDATA,
    input  logic                  M_READY
);

    // Counter value during the last permitted ACCESS cycle.
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    dmem_state_t           r_state;
    dmem_state_t           w_state_nxt;
    acc_req_t              w_dec;
    acc_req_t              r_req;
    logic                  w_st_vld;
    logic                  w_ld_vld;
    logic                  w_req_vld;
    logic                  w_misaligned;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be;
    logic                  w_busy;
    logic                  w_latch;
    logic                  w_set_mis;
    logic                  w_set_to;
    logic                  w_capture;
    logic [31:0]           w_load_val;
    logic [1:0]            r_offset;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-3:0] r_m_addr;
    logic [31:0]           r_m_wdata;
    logic [3:0]            r_m_be;
    logic [31:0]           r_rdata;
    logic                  r_misaligned;
    logic                  r_timeout;

    // Request decode: a valid store code masks any load code.
    always_comb begin
        w_st_vld          = 1'b0;
        w_ld_vld          = 1'b0;
        w_dec.is_store    = 1'b0;
        w_dec.size        = SZ_WORD;
        w_dec.is_unsigned = 1'b0;
        case (MEM_WRITE)
            MEM_B:   begin w_st_vld = 1'b1; w_dec.size = SZ_BYTE; end
            MEM_H:   begin w_st_vld = 1'b1; w_dec.size = SZ_HALF; end
            MEM_W:   begin w_st_vld = 1'b1; w_dec.size = SZ_WORD; end
            default: ;
        endcase
        if (w_st_vld) begin
            w_dec.is_store = 1'b1;
        end else begin
            case (MEM_READ)
                MEM_NONE: ;
                MEM_B:    begin w_ld_vld = 1'b1; w_dec.size = SZ_BYTE; end
                MEM_H:    begin w_ld_vld = 1'b1; w_dec.size = SZ_HALF; end
                MEM_W:    begin w_ld_vld = 1'b1; w_dec.size = SZ_WORD; end
                MEM_BU:   begin w_ld_vld = 1'b1; w_dec.size = SZ_BYTE; w_dec.is_unsigned = 1'b1; end
                MEM_HU:   begin w_ld_vld = 1'b1; w_dec.size = SZ_HALF; w_dec.is_unsigned = 1'b1; end
                default:  ;
            endcase
        end
    end

    assign w_req_vld    = w_st_vld | w_ld_vld;
    assign w_misaligned = w_req_vld & is_misaligned(w_dec.size, ADDRESS[1:0]);

    // Store lane placement: data is replicated across all lanes, byte enables pick the target.
    always_comb begin
        w_wdata = '0;
        w_be    = '0;
        if (w_st_vld) begin
            case (w_dec.size)
                SZ_BYTE: begin
                    w_wdata = {4{WRITE_DATA[7:0]}};
                    w_be    = 4'b0001 << ADDRESS[1:0];
                end
                SZ_HALF: begin
                    w_wdata = {2{WRITE_DATA[15:0]}};
                    w_be    = 4'b0011 << {ADDRESS[1], 1'b0};
                end
                default: begin
                    w_wdata = WRITE_DATA;
                    w_be    = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_latch     = 1'b0;
        w_set_mis   = 1'b0;
        w_set_to    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = w_req_vld;
                if (w_req_vld) begin
                    if (w_misaligned) begin
                        w_set_mis   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                w_busy = 1'b1;
                // M_READY has priority over a timeout in the same cycle.
                if (M_READY) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == LP_TO_LAST) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            // The completing instruction is still on the inputs here, so they are ignored.
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .i_word     (M_RDATA),
        .i_size     (r_req.size),
        .i_unsigned (r_req.is_unsigned),
        .i_offset   (r_offset),
        .o_result   (w_load_val)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_req.is_store    <= 1'b0;
            r_req.size        <= SZ_BYTE;
            r_req.is_unsigned <= 1'b0;
            r_offset          <= '0;
            r_cnt             <= '0;
            r_m_addr          <= '0;
            r_m_wdata         <= '0;
            r_m_be            <= '0;
            r_rdata           <= '0;
            r_misaligned      <= 1'b0;
            r_timeout         <= 1'b0;
        end else begin
            // Flags are set on the edge into DONE and clear on the edge out of it.
            r_misaligned <= w_set_mis;
            r_timeout    <= w_set_to;
            r_cnt        <= (r_state == ST_ACCESS) ? r_cnt + 8'd1 : 8'd0;
            if (w_latch) begin
                r_req     <= w_dec;
                r_offset  <= ADDRESS[1:0];
                r_m_addr  <= ADDRESS[ADDR_WIDTH-1:2];
                r_m_wdata <= w_wdata;
                r_m_be    <= w_be;
            end
            if (w_capture && !r_req.is_store) begin
                r_rdata <= w_load_val;
            end else if (w_set_mis || w_set_to) begin
                r_rdata <= '0;
            end
        end
    end

    // Gate the combinational IDLE stall with reset so BUSY reads 0 while reset is held.
    assign BUSY       = w_busy & ~RESET;
    assign M_READ     = (r_state == ST_ACCESS) & ~r_req.is_store;
    assign M_WRITE    = (r_state == ST_ACCESS) &  r_req.is_store;
    assign M_ADDR     = r_m_addr;
    assign M_WDATA    = r_m_wdata;
    assign M_BYTE_EN  = r_m_be;
    assign READ_DATA  = r_rdata;
    assign MISALIGNED = r_misaligned;
    assign TIMEOUT    = r_timeout;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
    import mem_access_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [2:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY;
    logic        MISALIGNED;
    logic        TIMEOUT;
    logic        M_READ;
    logic        M_WRITE;
    logic [29:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [3:0]  M_BYTE_EN;
    logic [31:0] M_RDATA;
    logic        M_READY;

    int n_checks = 0;
    int n_errors = 0;

    dmem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSY(BUSY),
        .MISALIGNED(MISALIGNED), .TIMEOUT(TIMEOUT), .M_READ(M_READ), .M_WRITE(M_WRITE),
        .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_BYTE_EN(M_BYTE_EN), .M_RDATA(M_RDATA),
        .M_READY(M_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        MEM_READ = 3'b000; MEM_WRITE = 3'b000; M_READY = 1'b0;
    endtask

    // Load with M_READY in the first ACCESS cycle; returns at the DONE-cycle negedge.
    task automatic run_load(input logic [2:0] code, input logic [31:0] addr, input logic [31:0] rdata);
        @(negedge CLK);
        MEM_READ = code; ADDRESS = addr; M_RDATA = rdata; M_READY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_reset();
        RESET = 1'b0; clear_inputs(); ADDRESS = '0; WRITE_DATA = '0; M_RDATA = '0;
        #2 RESET = 1'b1;
        #1;
        n_checks++; if ({BUSY, MISALIGNED, TIMEOUT, M_READ, M_WRITE} !== 5'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b want 00000", {BUSY, MISALIGNED, TIMEOUT, M_READ, M_WRITE}); end
        n_checks++; if (READ_DATA !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", READ_DATA); end
        n_checks++; if ({M_ADDR, M_WDATA, M_BYTE_EN} !== 66'h0) begin n_errors++; $display("FAIL reset_mem: got %h %h %b want 0", M_ADDR, M_WDATA, M_BYTE_EN); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_lw();
        @(negedge CLK);
        MEM_READ = MEM_W; ADDRESS = 32'h0000_0010; M_RDATA = 32'hDEAD_BEEF; M_READY = 1'b1;
        #1;
        n_checks++; if ({BUSY, M_READ} !== 2'b10) begin n_errors++; $display("FAIL lw_idle: busy/mread got %b want 10", {BUSY, M_READ}); end
        @(negedge CLK);
        n_checks++; if ({BUSY, M_READ, M_WRITE} !== 3'b110) begin n_errors++; $display("FAIL lw_access: busy/mread/mwrite got %b want 110", {BUSY, M_READ, M_WRITE}); end
        n_checks++; if (M_ADDR !== 30'h4) begin n_errors++; $display("FAIL lw_maddr: got %h want 4", M_ADDR); end
        n_checks++; if (M_BYTE_EN !== 4'b0000) begin n_errors++; $display("FAIL lw_be: got %b want 0000", M_BYTE_EN); end
        @(negedge CLK);
        n_checks++; if ({BUSY, M_READ, MISALIGNED, TIMEOUT} !== 4'b0000) begin n_errors++; $display("FAIL lw_done_ctrl: got %b want 0000", {BUSY, M_READ, MISALIGNED, TIMEOUT}); end
        n_checks++; if (READ_DATA !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_done_rdata: got %h want deadbeef", READ_DATA); end
        clear_inputs();
        @(negedge CLK);
        n_checks++; if ({BUSY, M_READ} !== 2'b00) begin n_errors++; $display("FAIL lw_back_idle: got %b want 00", {BUSY, M_READ}); end
        n_checks++; if (READ_DATA !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_rdata_hold: got %h want deadbeef", READ_DATA); end
    endtask

    task automatic test_lb_lh_lbu();
        run_load(MEM_B, 32'h13, 32'h80FF_7F01);
        n_checks++; if (READ_DATA !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_sext: got %h want ffffff80", READ_DATA); end
        run_load(MEM_H, 32'h12, 32'h80FF_7F01);
        n_checks++; if (READ_DATA !== 32'hFFFF_80FF) begin n_errors++; $display("FAIL lh_sext: got %h want ffff80ff", READ_DATA); end
        run_load(MEM_BU, 32'h13, 32'h80FF_7F01);
        n_checks++; if (READ_DATA !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_zext: got %h want 00000080", READ_DATA); end
    endtask

    task automatic test_sh_wait();
        int hi;
        @(negedge CLK);
        MEM_WRITE = MEM_H; ADDRESS = 32'h22; WRITE_DATA = 32'h1234_ABCD; M_READY = 1'b0;
        #1;
        n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL sh_idle_busy: got %b want 1", BUSY); end
        @(negedge CLK);
        hi = (M_WRITE === 1'b1) ? 1 : 0;
        n_checks++; if (M_WDATA !== 32'hABCD_ABCD) begin n_errors++; $display("FAIL sh_wdata: got %h want abcdabcd", M_WDATA); end
        n_checks++; if (M_BYTE_EN !== 4'b1100) begin n_errors++; $display("FAIL sh_be: got %b want 1100", M_BYTE_EN); end
        n_checks++; if ({M_ADDR, M_READ} !== {30'h8, 1'b0}) begin n_errors++; $display("FAIL sh_addr: got %h/%b want 8/0", M_ADDR, M_READ); end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            if (M_WRITE === 1'b1) hi++;
            if (i == 1) M_READY = 1'b1;
        end
        @(negedge CLK);
        n_checks++; if (hi !== 3) begin n_errors++; $display("FAIL sh_write_cycles: got %0d want 3", hi); end
        n_checks++; if ({BUSY, M_WRITE} !== 2'b00) begin n_errors++; $display("FAIL sh_done: busy/mwrite got %b want 00", {BUSY, M_WRITE}); end
        n_checks++; if (READ_DATA !== 32'h0000_0080) begin n_errors++; $display("FAIL sh_rdata_kept: got %h want 00000080", READ_DATA); end
        clear_inputs();
    endtask

    task automatic test_store_wins();
        @(negedge CLK);
        MEM_WRITE = MEM_B; MEM_READ = MEM_W; ADDRESS = 32'h01; WRITE_DATA = 32'hFFFF_FFA5; M_READY = 1'b1;
        @(negedge CLK);
        n_checks++; if ({M_WRITE, M_READ} !== 2'b10) begin n_errors++; $display("FAIL sb_wins_strobe: got %b want 10", {M_WRITE, M_READ}); end
        n_checks++; if ({M_WDATA, M_BYTE_EN} !== {32'hA5A5_A5A5, 4'b0010}) begin n_errors++; $display("FAIL sb_lanes: got %h/%b want a5a5a5a5/0010", M_WDATA, M_BYTE_EN); end
        @(negedge CLK);
        n_checks++; if (MISALIGNED !== 1'b0) begin n_errors++; $display("FAIL sb_wins_nomis: got %b want 0", MISALIGNED); end
        clear_inputs();
    endtask

    task automatic test_misaligned();
        run_load(MEM_HU, 32'h02, 32'h8001_1234);
        n_checks++; if (READ_DATA !== 32'h0000_8001) begin n_errors++; $display("FAIL lhu_zext: got %h want 00008001", READ_DATA); end
        @(negedge CLK);
        MEM_READ = MEM_W; ADDRESS = 32'h06;
        #1;
        n_checks++; if ({BUSY, M_READ} !== 2'b10) begin n_errors++; $display("FAIL lw_mis_idle: got %b want 10", {BUSY, M_READ}); end
        @(negedge CLK);
        n_checks++; if ({MISALIGNED, BUSY, M_READ} !== 3'b100) begin n_errors++; $display("FAIL lw_mis_done: mis/busy/mread got %b want 100", {MISALIGNED, BUSY, M_READ}); end
        n_checks++; if (READ_DATA !== 32'h0) begin n_errors++; $display("FAIL lw_mis_rdata: got %h want 0", READ_DATA); end
        n_checks++; if (M_ADDR !== 30'h0) begin n_errors++; $display("FAIL lw_mis_maddr: got %h want 0", M_ADDR); end
        clear_inputs();
        @(negedge CLK);
        n_checks++; if (MISALIGNED !== 1'b0) begin n_errors++; $display("FAIL lw_mis_pulse: got %b want 0", MISALIGNED); end
        MEM_WRITE = MEM_H; ADDRESS = 32'h05; WRITE_DATA = 32'h0000_BEEF;
        @(negedge CLK);
        n_checks++; if ({MISALIGNED, M_WRITE, BUSY} !== 3'b100) begin n_errors++; $display("FAIL sh_mis_done: mis/mwrite/busy got %b want 100", {MISALIGNED, M_WRITE, BUSY}); end
        n_checks++; if (M_BYTE_EN !== 4'b0000) begin n_errors++; $display("FAIL sh_mis_be: got %b want 0000", M_BYTE_EN); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int hi;
        logic seen;
        // Ready arriving in the last allowed cycle must beat the timeout.
        @(negedge CLK);
        MEM_READ = MEM_W; ADDRESS = 32'h44; M_RDATA = 32'h0BAD_C0DE; M_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 3) M_READY = 1'b1;
        end
        @(negedge CLK);
        n_checks++; if (TIMEOUT !== 1'b0) begin n_errors++; $display("FAIL to_coincide_flag: got %b want 0", TIMEOUT); end
        n_checks++; if (READ_DATA !== 32'h0BAD_C0DE) begin n_errors++; $display("FAIL to_coincide_rdata: got %h want 0badc0de", READ_DATA); end
        clear_inputs();
        @(negedge CLK);
        MEM_READ = MEM_W; ADDRESS = 32'h48; M_RDATA = 32'hFFFF_FFFF; M_READY = 1'b0;
        hi = 0; seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge CLK);
            if (M_READ === 1'b1) hi++;
            if (TIMEOUT === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL to_pulse_seen: got %b want 1 within 12 cycles", seen); end
        n_checks++; if (hi !== 4) begin n_errors++; $display("FAIL to_mread_cycles: got %0d want 4", hi); end
        n_checks++; if ({READ_DATA, BUSY} !== 33'h0) begin n_errors++; $display("FAIL to_done: rdata/busy got %h/%b want 0/0", READ_DATA, BUSY); end
        clear_inputs();
        @(negedge CLK);
        n_checks++; if ({TIMEOUT, BUSY, M_READ} !== 3'b000) begin n_errors++; $display("FAIL to_back_idle: got %b want 000", {TIMEOUT, BUSY, M_READ}); end
    endtask

    task automatic test_reset_mid();
        run_load(MEM_W, 32'h10, 32'h5555_AAAA);
        @(negedge CLK);
        MEM_READ = MEM_W; ADDRESS = 32'h20; M_READY = 1'b0;
        @(negedge CLK);
        n_checks++; if (M_READ !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre: mread got %b want 1", M_READ); end
        #2 RESET = 1'b1;
        #1;
        n_checks++; if ({M_READ, BUSY} !== 2'b00) begin n_errors++; $display("FAIL rst_mid_async: mread/busy got %b want 00", {M_READ, BUSY}); end
        n_checks++; if ({READ_DATA, M_ADDR} !== 62'h0) begin n_errors++; $display("FAIL rst_mid_regs: rdata/maddr got %h/%h want 0/0", READ_DATA, M_ADDR); end
        @(negedge CLK);
        RESET = 1'b0; clear_inputs();
        @(negedge CLK);
        n_checks++; if ({BUSY, M_READ, M_WRITE} !== 3'b000) begin n_errors++; $display("FAIL rst_after_idle: got %b want 000", {BUSY, M_READ, M_WRITE}); end
    endtask

    task automatic test_reserved();
        logic [2:0] rd_codes [4];
        logic [2:0] wr_codes [4];
        rd_codes = '{3'b110, 3'b111, 3'b000, 3'b110};
        wr_codes = '{3'b000, 3'b000, 3'b100, 3'b111};
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            MEM_READ = rd_codes[k]; MEM_WRITE = wr_codes[k]; ADDRESS = 32'h0;
            #1;
            n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL reserved_busy[%0d]: got %b want 0", k, BUSY); end
            @(negedge CLK);
            n_checks++; if ({BUSY, M_READ, M_WRITE} !== 3'b000) begin n_errors++; $display("FAIL reserved_mem[%0d]: got %b want 000", k, {BUSY, M_READ, M_WRITE}); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lh_lbu();
        test_sh_wait();
        test_store_wins();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_reserved();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
